// File: rtl/vga_timing_640_480.sv
// 640x480@60 raster timing generator: pixel tick, h/v position counters, sync/active decode.
// Define VGA_TIMING_FRAME_CNT_EN to add the 16-bit o_frame_cnt frame counter output.
module vga_timing_640_480 #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic        clk,
  input  logic        i_sclr_n,
  output logic        o_px_clk,
  output logic        o_hsync_en,
  output logic        o_vsync_en,
  output logic        o_haddr_en,
  output logic        o_vaddr_en,
  output logic [9:0]  o_hidx,
  output logic [9:0]  o_vidx,
  output logic        o_vga_hsync,
  output logic        o_vga_vsync,
  output logic        o_frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       hcount;
  logic [9:0]       vcount;
  logic             frame_wrap;

  logic tick;
  logic h_last;
  logic v_last;
  logic h_vis;
  logic v_vis;
  logic h_sync;
  logic v_sync;

  assign tick   = (div == DIV_LAST);
  assign h_last = (hcount == H_LAST);
  assign v_last = (vcount == V_LAST);
  assign h_vis  = (hcount < H_VIS_END);
  assign v_vis  = (vcount < V_VIS_END);
  assign h_sync = (hcount >= H_SYNC_BEG) && (hcount < H_SYNC_END);
  assign v_sync = (vcount >= V_SYNC_BEG) && (vcount < V_SYNC_END);

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      div        <= '0;
      hcount     <= '0;
      vcount     <= '0;
      frame_wrap <= 1'b0;
    end else begin
      // Marks the edge where the counters return to (0,0) after a complete frame.
      frame_wrap <= tick && h_last && v_last;
      if (tick) begin
        div <= '0;
        if (h_last) begin
          hcount <= '0;
          vcount <= v_last ? '0 : vcount + 10'd1;
        end else begin
          hcount <= hcount + 10'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Outputs are a registered view of the counters, one clk behind them.
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      o_px_clk      <= 1'b0;
      o_hsync_en    <= 1'b0;
      o_vsync_en    <= 1'b0;
      o_haddr_en    <= 1'b0;
      o_vaddr_en    <= 1'b0;
      o_hidx        <= '0;
      o_vidx        <= '0;
      o_vga_hsync   <= 1'b1;
      o_vga_vsync   <= 1'b1;
      o_frame_start <= 1'b0;
    end else begin
      o_px_clk      <= tick;
      o_hsync_en    <= h_sync;
      o_vsync_en    <= v_sync;
      o_haddr_en    <= h_vis;
      o_vaddr_en    <= v_vis;
      o_hidx        <= hcount;
      o_vidx        <= vcount;
      o_vga_hsync   <= ~h_sync;
      o_vga_vsync   <= ~v_sync;
      o_frame_start <= frame_wrap;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      o_frame_cnt <= '0;
    end else if (frame_wrap) begin
      o_frame_cnt <= o_frame_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_640_480.sv
// Directed bench: full-size instance for reset/line timing, reduced-size instance for frame timing.
// The reduced instance keeps whole frames (and mid-frame reset) within a short run.
`timescale 1ns/1ps
module tb_vga_timing_640_480;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;

  logic       a_px, a_hs, a_vs, a_ha, a_va, a_hpin, a_vpin, a_fs;
  logic [9:0] a_hidx, a_vidx;
  logic       b_px, b_hs, b_vs, b_ha, b_va, b_hpin, b_vpin, b_fs;
  logic [9:0] b_hidx, b_vidx;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] a_cnt, b_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  vga_timing_640_480 dut (
    .clk           (clk),
    .i_sclr_n      (rst_a),
    .o_px_clk      (a_px),
    .o_hsync_en    (a_hs),
    .o_vsync_en    (a_vs),
    .o_haddr_en    (a_ha),
    .o_vaddr_en    (a_va),
    .o_hidx        (a_hidx),
    .o_vidx        (a_vidx),
    .o_vga_hsync   (a_hpin),
    .o_vga_vsync   (a_vpin),
    .o_frame_start (a_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .o_frame_cnt   (a_cnt)
`endif
  );

  // Small raster: CLK_DIV 2, 15 px/line (hsync at 10..12), 10 lines/frame (vsync lines 7..8).
  vga_timing_640_480 #(
    .CLK_DIV   (2),
    .H_VISIBLE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_VISIBLE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
  ) dut_s (
    .clk           (clk),
    .i_sclr_n      (rst_b),
    .o_px_clk      (b_px),
    .o_hsync_en    (b_hs),
    .o_vsync_en    (b_vs),
    .o_haddr_en    (b_ha),
    .o_vaddr_en    (b_va),
    .o_hidx        (b_hidx),
    .o_vidx        (b_vidx),
    .o_vga_hsync   (b_hpin),
    .o_vga_vsync   (b_vpin),
    .o_frame_start (b_fs)
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    .o_frame_cnt   (b_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs the small instance for n_clk clks after a reset release (k=1 is the first clk).
  // A frame is 15*10*2 = 300 clks, so frame_start is expected at k = 301, 601, ...
  task automatic run_small(input int n_clk, input int force_k);
    int pix, h, v;
    int e_pos = 0, e_reg = 0, e_pin = 0, e_px = 0, e_fs = 0;
    int n_fs = 0, first_fs = -1, n_vs = 0;
    bit fs_exp;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] exp_cnt = 16'h0;
    int e_cnt = 0;
`endif
    for (int k = 1; k <= n_clk; k++) begin
      step();
      pix    = (k - 1) / 2;
      h      = pix % 15;
      v      = (pix / 15) % 10;
      fs_exp = (k > 1) && ((k - 1) % 300 == 0);
      if (b_hidx !== 10'(h) || b_vidx !== 10'(v)) e_pos++;
      if (b_ha !== (h < 8) || b_hs !== (h >= 10 && h <= 12) ||
          b_va !== (v < 6) || b_vs !== (v == 7 || v == 8)) e_reg++;
      if (b_hpin !== ~b_hs || b_vpin !== ~b_vs) e_pin++;
      if (b_px !== (k % 2 == 0)) e_px++;
      if (b_fs !== fs_exp) e_fs++;
      if (b_fs === 1'b1) begin
        n_fs++;
        if (first_fs < 0) first_fs = k;
      end
      if (k <= 300 && b_vs === 1'b1) n_vs++;
`ifdef VGA_TIMING_FRAME_CNT_EN
      if (fs_exp) begin
        exp_cnt = exp_cnt + 16'd1;
        check("frame_cnt_step", 32'(b_cnt), 32'(exp_cnt));
      end else if (b_cnt !== exp_cnt) begin
        e_cnt++;
      end
      if (k == force_k) begin
        force dut_s.o_frame_cnt = 16'hFFFF;
        #1;
        release dut_s.o_frame_cnt;
        exp_cnt = 16'hFFFF;
      end
`endif
    end
    check("s_position", e_pos, 0);
    check("s_regions", e_reg, 0);
    check("s_pins", e_pin, 0);
    check("s_px_period", e_px, 0);
    check("s_fs_timing", e_fs, 0);
    check("s_fs_first", first_fs, 301);
    check("s_fs_count", n_fs, (n_clk - 1) / 300);
    check("s_vsync_clks", n_vs, 60);
`ifdef VGA_TIMING_FRAME_CNT_EN
    check("frame_cnt_hold", e_cnt, 0);
`endif
  endtask

  initial begin
    int pix, h, v;
    int e_h = 0, e_v = 0, e_px = 0, e_pin = 0, e_reg = 0;
    int n_ha = 0, n_hs = 0, n_va = 0, n_fs = 0;
    int hs_min = 1023, hs_max = -1;
    bit found;

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (5) step();
    check("rst_px", a_px, 0);
    check("rst_hsync_en", a_hs, 0);
    check("rst_vsync_en", a_vs, 0);
    check("rst_haddr", a_ha, 0);
    check("rst_vaddr", a_va, 0);
    check("rst_idx", {a_hidx, a_vidx}, 0);
    check("rst_pins", {a_hpin, a_vpin}, 2'b11);
    check("rst_fs", a_fs, 0);

    // Two full lines plus a few pixels of the full-size instance (3200 clks per line).
    rst_a = 1'b1;
    for (int k = 1; k <= 6404; k++) begin
      step();
      pix = (k - 1) / 4;
      h   = pix % 800;
      v   = pix / 800;
      if (a_hidx !== 10'(h)) e_h++;
      if (a_vidx !== 10'(v)) e_v++;
      if (a_px !== (k % 4 == 0)) e_px++;
      if (a_hpin !== ~a_hs || a_vpin !== ~a_vs) e_pin++;
      if (a_ha !== (h < 640) || a_hs !== (h >= 656 && h <= 751) ||
          a_va !== 1'b1 || a_vs !== 1'b0) e_reg++;
      if (a_fs === 1'b1) n_fs++;
      if (k <= 3200) begin
        if (a_ha === 1'b1) n_ha++;
        if (a_va === 1'b1) n_va++;
        if (a_hs === 1'b1) begin
          n_hs++;
          if (int'(a_hidx) < hs_min) hs_min = int'(a_hidx);
          if (int'(a_hidx) > hs_max) hs_max = int'(a_hidx);
        end
      end
      if (k == 1) begin
        check("first_idx", {a_hidx, a_vidx}, 0);
        check("first_addr_en", {a_ha, a_va}, 2'b11);
        check("first_pins", {a_hpin, a_vpin}, 2'b11);
      end
      if (k <= 4) check("first_px", a_px, (k == 4));
      if (k == 3200) check("line_end", {a_hidx, a_vidx}, {10'd799, 10'd0});
      if (k == 3201) check("line_wrap", {a_hidx, a_vidx}, {10'd0, 10'd1});
    end
    check("hidx_model", e_h, 0);
    check("vidx_model", e_v, 0);
    check("px_period", e_px, 0);
    check("sync_pins", e_pin, 0);
    check("regions", e_reg, 0);
    check("haddr_clks", n_ha, 640 * 4);
    check("hsync_clks", n_hs, 96 * 4);
    check("hsync_first", hs_min, 656);
    check("hsync_last", hs_max, 751);
    check("vaddr_clks", n_va, 3200);
    check("no_fs_in_lines", n_fs, 0);

    // Small instance: reset values, then three frames.
    check("s_rst_idx", {b_hidx, b_vidx}, 0);
    check("s_rst_pins", {b_hpin, b_vpin, b_px, b_fs}, 4'b1100);
    rst_b = 1'b1;
    run_small(930, 0);

    // Mid-frame reset at (11,4), then one frame plus a line of normal timing.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (b_hidx == 10'd11 && b_vidx == 10'd4) found = 1'b1;
    end
    check("wait_mid_frame", found, 1);
    rst_b = 1'b0;
    step();
    check("mid_rst_idx", {b_hidx, b_vidx}, 0);
    check("mid_rst_flags", {b_ha, b_va, b_fs, b_hpin, b_vpin}, 5'b00011);
    rst_b = 1'b1;
    run_small(330, 150);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_640_480.md
Name: vga_timing_640_480

Overview:
Upstream raster timing generator for the 640x480@60 VGA path. It divides the system clock into a pixel-rate tick and runs horizontal and vertical position counters. From those counters it produces the sync, active-area and index signals that the pixel/colour generator consumes, plus the physical active-low HSYNC/VSYNC pins.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); must be >= 2
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels); H_TOTAL = sum of the four = 800
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines); V_TOTAL = 525

Ports:
clk  in  1  system clock; the only clock
i_sclr_n  in  1  synchronous active-low reset
o_px_clk  out  1  pixel tick: one-clk pulse every CLK_DIV clks (clock enable, not a clock)
o_hsync_en  out  1  high while hcount is in the horizontal sync region
o_vsync_en  out  1  high while vcount is in the vertical sync region
o_haddr_en  out  1  high while hcount < H_VISIBLE
o_vaddr_en  out  1  high while vcount < V_VISIBLE
o_hidx  out  10  current hcount, 0..H_TOTAL-1
o_vidx  out  10  current vcount, 0..V_TOTAL-1
o_vga_hsync  out  1  pin, = ~o_hsync_en
o_vga_vsync  out  1  pin, = ~o_vsync_en
o_frame_start  out  1  one-clk pulse when the counters move to (0,0)

Behaviour:
- Reset is synchronous and active-low. While i_sclr_n=0 at a clk edge:
  - divider, hcount and vcount clear to 0
  - all outputs go to their reset values: o_px_clk=0, o_hsync_en=0, o_vsync_en=0, o_haddr_en=0, o_vaddr_en=0, o_hidx=0, o_vidx=0, o_vga_hsync=1, o_vga_vsync=1, o_frame_start=0
- Divider: counts 0..CLK_DIV-1 and wraps. Tick is asserted when divider == CLK_DIV-1.
- o_px_clk is registered: it is high for the clk after the divider reaches CLK_DIV-1.
- First o_px_clk after reset release: high on the CLK_DIV-th clk edge after release.
- hcount advances on tick. When hcount == H_TOTAL-1 it wraps to 0 and the line advances.
- vcount advances only on a tick where hcount wraps. When vcount == V_TOTAL-1 it wraps to 0.
- Region decode (horizontal; vertical uses the same pattern with V_* parameters):
  - visible: [0, H_VISIBLE)
  - front porch: [H_VISIBLE, H_VISIBLE+H_FP)
  - sync: [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC) = 656..751
  - back porch: remainder up to H_TOTAL-1
  - Vertical sync lines: 490..491.
- Every output is registered from the current counter values, so outputs lag the counters by exactly 1 clk.
  - The first clk after reset release shows (0,0): o_haddr_en=1, o_vaddr_en=1, sync pins high.
- o_frame_start pulses for 1 clk, coincident with the output update where o_hidx and o_vidx both become 0 after a full-frame wrap. It does not pulse for the post-reset (0,0).
- Counter widths are 10 bits. No counter ever reaches 800 (h) or 525 (v).
- Reset asserted mid-line or mid-frame takes priority over the tick: counters restart at (0,0) with no partial-frame completion and no frame_start pulse.
- The period of o_hidx is exactly H_TOTAL*CLK_DIV clks per line. The frame period is H_TOTAL*V_TOTAL*CLK_DIV = 1,680,000 clks.

Optional Feature:
Macro: VGA_TIMING_FRAME_CNT_EN.
- Defined: adds output port o_frame_cnt [15:0].
  - Reset value 0.
  - Increments by 1, registered, in the same clk that o_frame_start pulses.
  - Wraps 0xFFFF -> 0x0000.
  - Intended for blink/animation in the colour stage.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: hold i_sclr_n=0 for 5 clks, then release -> during reset all outputs are at their reset values (o_vga_hsync=1, o_vga_vsync=1); 1 clk after release o_hidx=0, o_vidx=0, o_haddr_en=1, o_vaddr_en=1; the first o_px_clk comes 4 clks after release.
- Line timing: run one line -> o_haddr_en high for 640 ticks; o_hsync_en high for exactly 96 ticks at o_hidx 656..751; o_vga_hsync is its inverse; o_hidx wraps 799 -> 0 and o_vidx increments 0 -> 1 on the same output update.
- Frame timing: run one full frame -> o_vsync_en high exactly while o_vidx is 490..491 (2 lines = 1600 ticks); o_vaddr_en high for o_vidx 0..479; o_frame_start pulses once, 1,680,000 clks after the first post-reset (0,0).
- Mid-frame reset: assert i_sclr_n=0 for 1 clk at o_hidx=700, o_vidx=300 -> counters restart at (0,0); no o_frame_start pulse; the next line is timed normally.
- Pulse shapes: o_px_clk and o_frame_start are each exactly 1 clk wide; o_px_clk has a period of exactly 4 clks throughout a frame.
- VGA_TIMING_FRAME_CNT_EN defined: run 3 frames -> o_frame_cnt reads 1, 2, 3, each step aligned with its o_frame_start pulse; force a wrap from 0xFFFF -> 0x0000.
